// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the RX frame controller and its pin/sampler/checker neighbours.
// UART_RX_ERR_FLAGS_EN adds the per-frame error pulses frm_par_err/frm_stp_err.
interface uart_rx_fsm_if #(
    parameter int PRESC_W = 6
);
    logic               rx_in;
    logic [PRESC_W-1:0] prescale;
    logic               par_en;
    logic               sample_valid;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               dat_samp_en;
    logic               strt_chk_en;
    logic               deser_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               busy;
`ifdef UART_RX_ERR_FLAGS_EN
    logic               frm_par_err;
    logic               frm_stp_err;

    modport master (
        output rx_in, prescale, par_en, sample_valid, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
               stp_chk_en, data_valid, busy, frm_par_err, frm_stp_err
    );

    modport slave (
        input  rx_in, prescale, par_en, sample_valid, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
               stp_chk_en, data_valid, busy, frm_par_err, frm_stp_err
    );
`else
    modport master (
        output rx_in, prescale, par_en, sample_valid, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
               stp_chk_en, data_valid, busy
    );

    modport slave (
        input  rx_in, prescale, par_en, sample_valid, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en,
               stp_chk_en, data_valid, busy
    );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART RX frame controller: walks START/DATA/PARITY/STOP, enables the checkers in turn,
// and pulses data_valid for clean frames. UART_RX_ERR_FLAGS_EN adds frm_par_err/frm_stp_err.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ERR_CHK = 3'd5
    } state_t;

    localparam logic [3:0]         LAST_DATA_BIT = 4'(DATA_WIDTH);
    localparam logic [PRESC_W-1:0] EDGE_ONE      = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] EDGE_ZERO     = PRESC_W'(0);

    state_t             state_r;
    state_t             state_s;
    logic [PRESC_W-1:0] edge_cnt_r;
    logic [PRESC_W-1:0] edge_cnt_s;
    logic [PRESC_W-1:0] presc_r;
    logic [3:0]         bit_cnt_r;
    logic [3:0]         bit_cnt_s;
    logic               par_en_r;
    logic               par_err_r;
    logic               par_err_s;
    logic               stp_err_r;
    logic               stp_err_s;
    logic               bit_end_s;
    logic               dat_samp_en_r;
    logic               strt_chk_en_r;
    logic               deser_en_r;
    logic               par_chk_en_r;
    logic               stp_chk_en_r;
    logic               data_valid_r;
    logic               busy_r;
`ifdef UART_RX_ERR_FLAGS_EN
    logic               frm_par_err_r;
    logic               frm_stp_err_r;
`endif

    // Next state, bit/edge counters and error latches
    always_comb begin
        state_s    = state_r;
        edge_cnt_s = edge_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        par_err_s  = par_err_r;
        stp_err_s  = stp_err_r;
        bit_end_s  = (edge_cnt_r == (presc_r - EDGE_ONE));

        if ((state_r != IDLE) && (state_r != ERR_CHK)) begin
            if (bit_end_s) begin
                edge_cnt_s = EDGE_ZERO;
                bit_cnt_s  = bit_cnt_r + 4'd1;
            end else begin
                edge_cnt_s = edge_cnt_r + EDGE_ONE;
                bit_cnt_s  = bit_cnt_r;
            end
        end else begin
            edge_cnt_s = EDGE_ZERO;
            bit_cnt_s  = 4'd0;
        end

        case (state_r)
            IDLE: begin
                par_err_s = 1'b0;
                stp_err_s = 1'b0;
                // The low IDLE cycle already counts as edge 0 of the start bit
                if (!bus.rx_in) begin
                    state_s    = START;
                    edge_cnt_s = EDGE_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bus.sample_valid && bus.strt_glitch) begin
                    state_s    = IDLE;
                    edge_cnt_s = EDGE_ZERO;
                    bit_cnt_s  = 4'd0;
                end else if (bit_end_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_DATA_BIT)) begin
                    state_s = par_en_r ? PARITY : STOP;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bus.sample_valid && bus.par_err) begin
                    par_err_s = 1'b1;
                end else begin
                    par_err_s = par_err_r;
                end
                if (bit_end_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bus.sample_valid && bus.stp_err) begin
                    stp_err_s = 1'b1;
                end else begin
                    stp_err_s = stp_err_r;
                end
                if (bit_end_s) begin
                    state_s = ERR_CHK;
                end else begin
                    state_s = STOP;
                end
            end
            ERR_CHK: begin
                par_err_s = 1'b0;
                stp_err_s = 1'b0;
                // A low line here is the start of a back-to-back frame
                if (!bus.rx_in) begin
                    state_s    = START;
                    edge_cnt_s = EDGE_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s    = IDLE;
                edge_cnt_s = EDGE_ZERO;
                bit_cnt_s  = 4'd0;
                par_err_s  = 1'b0;
                stp_err_s  = 1'b0;
            end
        endcase
    end

    // State register, frame configuration capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            edge_cnt_r    <= EDGE_ZERO;
            bit_cnt_r     <= 4'd0;
            presc_r       <= EDGE_ZERO;
            par_en_r      <= 1'b0;
            par_err_r     <= 1'b0;
            stp_err_r     <= 1'b0;
            dat_samp_en_r <= 1'b0;
            strt_chk_en_r <= 1'b0;
            deser_en_r    <= 1'b0;
            par_chk_en_r  <= 1'b0;
            stp_chk_en_r  <= 1'b0;
            data_valid_r  <= 1'b0;
            busy_r        <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            frm_par_err_r <= 1'b0;
            frm_stp_err_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            edge_cnt_r <= edge_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            par_err_r  <= par_err_s;
            stp_err_r  <= stp_err_s;
            if (state_r == IDLE) begin
                presc_r  <= bus.prescale;
                par_en_r <= bus.par_en;
            end
            strt_chk_en_r <= (state_s == START);
            dat_samp_en_r <= (state_s == START) || (state_s == DATA);
            deser_en_r    <= (state_r == DATA) && bus.sample_valid;
            par_chk_en_r  <= (state_s == PARITY);
            stp_chk_en_r  <= (state_s == STOP);
            data_valid_r  <= (state_s == ERR_CHK) && !(par_err_s || stp_err_s);
            busy_r        <= (state_s != IDLE);
`ifdef UART_RX_ERR_FLAGS_EN
            frm_par_err_r <= (state_s == ERR_CHK) && par_err_s;
            frm_stp_err_r <= (state_s == ERR_CHK) && stp_err_s;
`endif
        end
    end

    assign bus.edge_cnt    = edge_cnt_r;
    assign bus.bit_cnt     = bit_cnt_r;
    assign bus.dat_samp_en = dat_samp_en_r;
    assign bus.strt_chk_en = strt_chk_en_r;
    assign bus.deser_en    = deser_en_r;
    assign bus.par_chk_en  = par_chk_en_r;
    assign bus.stp_chk_en  = stp_chk_en_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.busy        = busy_r;
`ifdef UART_RX_ERR_FLAGS_EN
    assign bus.frm_par_err = frm_par_err_r;
    assign bus.frm_stp_err = frm_stp_err_r;
`endif
endmodule
